// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned WIDTH_DEFAULT = 16;

endpackage

// File: rtl/mem_port_arbiter_mux2n1_w.sv
// WIDTH-wide combinational 2:1 select used on the memory port paths.
module mux2n1_w
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the CPU memory port: fetch (0) vs load/store (1),
// bounded hold with round-robin tie-breaking, grants and port select registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [WIDTH-1:0] Addr0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Addr1,
    input  logic [WIDTH-1:0] WData1,
    input  logic             We1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             S,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    output logic             MemWe,
    output logic             Busy
);

    localparam int unsigned       HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (Req0 && Req1)
                    state_d = last_q ? OWN0 : OWN1;
                else if (Req0)
                    state_d = OWN0;
                else if (Req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (Req0 && Req1) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = OWN1;
                        last_d  = 1'b0;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end else if (!Req0) begin
                    // Release: hand straight to a waiting requester, otherwise idle.
                    state_d = Req1 ? OWN1 : IDLE;
                    last_d  = 1'b0;
                    hold_d  = '0;
                end
            end
            OWN1: begin
                if (Req0 && Req1) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = OWN0;
                        last_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end else if (!Req1) begin
                    state_d = Req0 ? OWN0 : IDLE;
                    last_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign Gnt0  = gnt0_q;
    assign Gnt1  = gnt1_q;
    assign S     = gnt1_q;
    assign Busy  = gnt0_q | gnt1_q;
    assign MemWe = gnt1_q & We1;

    mux2n1_w #(.WIDTH(WIDTH)) u_addr_mux (
        .sel (gnt1_q),
        .in0 (Addr0),
        .in1 (Addr1),
        .out (MemAddr)
    );

    mux2n1_w #(.WIDTH(WIDTH)) u_wdata_mux (
        .sel (gnt1_q),
        .in0 ('0),
        .in1 (WData1),
        .out (MemWData)
    );

endmodule
